// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage multiply/divide unit owning HI/LO, with a registered Busy for hazard stalls.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic        md_we,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic [63:0] r_pend;
  logic        r_dz;
  logic [31:0] r_hi, r_lo;
  logic        w_go, w_div, w_sgn, w_dz;
  logic [31:0] w_ua, w_ub, w_den, w_uq, w_ur, w_q, w_r;
  logic [63:0] w_smul, w_umul, w_res;
  always_comb begin
    w_go   = r_state == IDLE && start && !md_op[2];
    w_div  = md_op[1];
    w_sgn  = !md_op[0];
    w_dz   = B == 32'd0;
    // Signed divide works on magnitudes so the overflow case falls out naturally.
    w_ua   = (w_sgn && A[31]) ? -A : A;
    w_ub   = (w_sgn && B[31]) ? -B : B;
    w_den  = w_dz ? 32'd1 : w_ub;
    w_uq   = w_ua / w_den;
    w_ur   = w_ua % w_den;
    w_q    = (w_sgn && (A[31] ^ B[31])) ? -w_uq : w_uq;
    w_r    = (w_sgn && A[31]) ? -w_ur : w_ur;
    w_smul = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    w_umul = {32'd0, A} * {32'd0, B};
    w_res  = w_div ? {w_r, w_q} : (w_sgn ? w_smul : w_umul);
    w_next = (r_state == IDLE) ? (w_go ? RUN : IDLE) : (r_cnt == 4'd1 ? IDLE : RUN);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_pend  <= 64'd0;
      r_dz    <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_go) begin
        r_cnt  <= w_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        r_pend <= w_res;
        r_dz   <= w_div && w_dz;
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt - 4'd1;
        if (r_cnt == 4'd1 && !r_dz) {r_hi, r_lo} <= r_pend;
      end else if (!start && md_we && md_op == 3'd4) r_hi <= A;
      else if (!start && md_we && md_op == 3'd5) r_lo <= A;
    end
  end
  assign Busy = r_state == RUN;
  assign HI   = r_hi;
  assign LO   = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed scoreboard bench for mult_div_unit.
module tb_mult_div_unit;
  logic        clk = 0, reset = 0, start = 0, md_we = 0;
  logic [2:0]  md_op = 0;
  logic [31:0] A = 0, B = 0, HI, LO;
  logic        Busy;
  int          checks = 0, failures = 0;
  typedef struct {int cyc; logic [63:0] hilo;} exp_t;
  exp_t sb[$];

  mult_div_unit dut (.clk(clk), .reset(reset), .start(start), .md_op(md_op), .md_we(md_we),
                     .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int cyc, input logic [63:0] hilo);
    exp_t e;
    e.cyc = cyc; e.hilo = hilo;
    sb.push_back(e);
    start = 1; md_op = op; A = a; B = b;
    @(negedge clk);
    start = 0;
  endtask

  task automatic run(input string tag, input bit interfere);
    exp_t e;
    int n = 0;
    e = sb.pop_front();
    while (Busy === 1'b1 && n < 40) begin
      n++;
      if (interfere && n == 1) begin start = 1; md_op = 2; A = 32'd9; B = 32'd0; end
      if (interfere && n == 2) begin start = 0; md_we = 1; md_op = 4; A = 32'hAAAA; end
      if (interfere && n == 3) md_we = 0;
      @(negedge clk);
    end
    chk({tag, " busy"}, 64'(n), 64'(e.cyc));
    chk({tag, " hilo"}, {HI, LO}, e.hilo);
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    md_we = 1; md_op = op; A = a;
    @(negedge clk);
    md_we = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(Busy), 64'd0);
    chk("reset hilo", {HI, LO}, 64'd0);
    reset = 1;
    @(negedge clk);
    issue(0, 32'hFFFFFFFF, 32'd2, 5, 64'hFFFFFFFF_FFFFFFFE);
    run("mult", 0);
    issue(1, 32'hFFFFFFFF, 32'd2, 5, 64'h00000001_FFFFFFFE);
    run("multu", 0);
    issue(2, 32'hFFFFFFF9, 32'd2, 10, 64'hFFFFFFFF_FFFFFFFD);
    run("div neg", 0);
    issue(3, 32'd7, 32'd2, 10, 64'h00000001_00000003);
    run("divu", 0);
    issue(2, 32'h80000000, 32'hFFFFFFFF, 10, 64'h00000000_80000000);
    run("div ovf", 0);
    issue(2, 32'd7, 32'hFFFFFFFE, 10, 64'h00000001_FFFFFFFD);
    run("div negb", 0);
    mt(4, 32'h11);
    chk("mthi", {HI, LO}, 64'h00000011_80000000 ^ 64'h0 ^ {32'h0, 32'h80000000} ^ {32'h0, 32'hFFFFFFFD});
    mt(5, 32'h22);
    chk("mtlo", {HI, LO}, 64'h00000011_00000022);
    issue(2, 32'd100, 32'd0, 10, 64'h00000011_00000022);
    run("div0", 0);
    chk("div0 idle", 64'(Busy), 64'd0);
    issue(3, 32'd5, 32'd0, 10, 64'h00000011_00000022);
    run("divu0", 0);
    issue(0, 32'd3, 32'd4, 5, 64'h00000000_0000000C);
    run("mult interfere", 1);
    start = 1; md_we = 1; md_op = 4; A = 32'h5555;
    @(negedge clk);
    start = 0; md_we = 0;
    chk("start beats md_we busy", 64'(Busy), 64'd0);
    chk("start beats md_we hilo", {HI, LO}, 64'h00000000_0000000C);
    start = 1; md_op = 0; A = 32'd7; B = 32'd8;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    chk("pre-abort busy", 64'(Busy), 64'd1);
    reset = 0;
    #1;
    chk("abort busy", 64'(Busy), 64'd0);
    chk("abort hilo", {HI, LO}, 64'd0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    issue(1, 32'd5, 32'd6, 5, 64'h00000000_0000001E);
    run("post-reset multu", 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout observed=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
